// File: rtl/wmult_ctrl.sv
// wmult_ctrl: sequencing FSM for the shift-add multiplier datapath.
// It loads P/Q, runs the add/shift iterations and captures the product into M.
// It also offers a start/busy/done handshake to the upstream sequencer.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; all datapath controls low
// LOAD   | clear accumulator, load Q into RQ and P into RP
// ITER   | datapath adds RP when RQ[0] is set, then shifts; cnt counts
// STORE  | capture the accumulator into M
// DONE   | one-cycle done pulse, M valid
module wmult_ctrl #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] RQ,
  output logic             RA,
  output logic             RRQ,
  output logic             RRP,
  output logic             EM,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ITER  = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rq_zero;
  logic            iter_exit;

  // Once RQ is zero, every remaining add contributes nothing, so the accumulator is already final.
  always_comb begin
    rq_zero   = (RQ == '0);
    iter_exit = (cnt_q == CNT_LAST) || (EARLY_EXIT && rq_zero);
  end

  // State and iteration counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        // abort is deliberately not looked at here; the datapath is only being reloaded
        cnt_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        // hold at the last count rather than wrapping; only LOAD reinitialises cnt
        if (cnt_q != CNT_LAST) cnt_d = cnt_q + CW'(1);
        if (abort)          state_d = S_IDLE;
        else if (iter_exit) state_d = S_STORE;
      end
      S_STORE: begin
        // EM is still high this cycle, so M is updated even when aborting
        if (abort) state_d = S_IDLE;
        else       state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore output decode, from the state register only.
  always_comb begin
    RA   = 1'b0;
    RRQ  = 1'b0;
    RRP  = 1'b0;
    EM   = 1'b0;
    done = 1'b0;
    busy = (state_q != S_IDLE);
    case (state_q)
      S_LOAD: begin
        RA  = 1'b1;
        RRQ = 1'b1;
        RRP = 1'b1;
      end
      S_STORE: EM   = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // The counter must stay within the iteration range.
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CNT_LAST);

  // A done pulse is always preceded by a STORE cycle.
  a_done_after_store: assert property (@(posedge clk) disable iff (!rst_n)
                                       (state_q == S_DONE) |-> $past(state_q == S_STORE));

endmodule

// File: tb/tb_wmult_ctrl.sv
// Bench for wmult_ctrl: two controllers, one with early exit and one without.
// Each controller drives a small behavioural shift-add datapath kept in the bench.
// A schedule model predicts the controls on every cycle.
// Directed operations pin the model with hand-computed latencies and products.
module tb_wmult_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start_v [2];
  logic       abort_v [2];
  logic [7:0] p_in    [2];
  logic [7:0] q_in    [2];
  logic       ra_v    [2];
  logic       rrq_v   [2];
  logic       rrp_v   [2];
  logic       em_v    [2];
  logic       busy_v  [2];
  logic       done_v  [2];

  // behavioural datapath state
  logic [7:0]  rq_a  [2];
  logic [15:0] rp_a  [2];
  logic [15:0] acc_a [2];
  logic [15:0] m_a   [2];

  // schedule model: t = cycles since LOAD (-1 when idle), n = ITER cycles of this op
  int  t_m    [2];
  int  n_m    [2];
  int  pq_m   [2];
  int  mexp_m [2];
  bit  mval_m [2];
  bit  cmp_en;

  int errors = 0;
  int checks = 0;

  wmult_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]), .RQ(rq_a[0]),
    .RA(ra_v[0]), .RRQ(rrq_v[0]), .RRP(rrp_v[0]), .EM(em_v[0]),
    .busy(busy_v[0]), .done(done_v[0]));

  wmult_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]), .RQ(rq_a[1]),
    .RA(ra_v[1]), .RRQ(rrq_v[1]), .RRP(rrp_v[1]), .EM(em_v[1]),
    .busy(busy_v[1]), .done(done_v[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Number of ITER cycles: each ITER cycle sees RQ = Q >> i.
  // The phase ends at i = 7 or, with early exit, when Q >> i == 0.
  function automatic int iters(input int q, input bit ee);
    int i;
    for (i = 0; i < 8; i++) begin
      if (i == 7) break;
      if (ee && ((q >> i) == 0)) break;
    end
    return i + 1;
  endfunction

  // Shift-add datapath responding to the controller's register controls.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rrq_v[i]) rq_a[i] <= q_in[i];
      else          rq_a[i] <= rq_a[i] >> 1;
      if (rrp_v[i]) rp_a[i] <= {8'd0, p_in[i]};
      else          rp_a[i] <= rp_a[i] << 1;
      if (ra_v[i])        acc_a[i] <= '0;
      else if (rq_a[i][0]) acc_a[i] <= acc_a[i] + rp_a[i];
      if (em_v[i]) m_a[i] <= acc_a[i];
    end
  end

  // Schedule model advance.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        t_m[i] = -1;
      end else if (t_m[i] < 0) begin
        if (start_v[i]) t_m[i] = 0;
      end else if (t_m[i] == 0) begin
        n_m[i]  = iters(int'(q_in[i]), (i == 0));
        pq_m[i] = int'(p_in[i]) * int'(q_in[i]);
        t_m[i]  = 1;
      end else if (t_m[i] <= n_m[i]) begin
        t_m[i] = abort_v[i] ? -1 : t_m[i] + 1;
      end else if (t_m[i] == n_m[i] + 1) begin
        mexp_m[i] = pq_m[i];
        mval_m[i] = 1'b1;
        t_m[i]    = abort_v[i] ? -1 : t_m[i] + 1;
      end else begin
        t_m[i] = -1;
      end
    end
  end

  // Per-cycle comparison of controls and M against the model.
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [5:0] exp_v, act_v;
        logic ld, em, dn, bz;
        ld = (t_m[i] == 0);
        em = (t_m[i] >= 1) && (t_m[i] == n_m[i] + 1);
        dn = (t_m[i] >= 1) && (t_m[i] == n_m[i] + 2);
        bz = (t_m[i] >= 0);
        exp_v = {ld, ld, ld, em, bz, dn};
        act_v = {ra_v[i], rrq_v[i], rrp_v[i], em_v[i], busy_v[i], done_v[i]};
        chk((i == 0) ? "ctl0" : "ctl1", int'(act_v), int'(exp_v));
        if (mval_m[i]) chk((i == 0) ? "m0" : "m1", int'(m_a[i]), mexp_m[i]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // start high in cycle 0; reports the cycle of done, first EM, number of LOAD cycles, first idle cycle.
  task automatic run_op(input int i, input int p, input int q, input int abort_at,
                        input int start_mask, output int lat, output int em_c,
                        output int load_n, output int end_c);
    p_in[i] = 8'(p);
    q_in[i] = 8'(q);
    start_v[i] = 1'b1;
    abort_v[i] = 1'b0;
    lat = -1; em_c = -1; load_n = 0; end_c = -1;
    for (int c = 1; c <= 60; c++) begin
      cyc();
      start_v[i] = (c < 32) && start_mask[c];
      abort_v[i] = (c == abort_at);
      if (rrq_v[i]) load_n++;
      if (em_v[i] && em_c < 0) em_c = c;
      if (done_v[i] && lat < 0) lat = c;
      if (!busy_v[i]) begin
        end_c = c;
        break;
      end
    end
    start_v[i] = 1'b0;
    abort_v[i] = 1'b0;
    chk("op_ends", int'(end_c > 0), 1);
  endtask

  initial begin
    int lat, em_c, load_n, end_c, d1, d2;
    rst_n  = 1'b0;
    cmp_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0; abort_v[i] = 1'b0; p_in[i] = '0; q_in[i] = '0;
      t_m[i] = -1; n_m[i] = 0; mval_m[i] = 1'b0; mexp_m[i] = 0; pq_m[i] = 0;
    end
    repeat (3) cyc();
    chk("reset_ctl0", int'({ra_v[0], rrq_v[0], rrp_v[0], em_v[0], busy_v[0], done_v[0]}), 0);
    chk("reset_ctl1", int'({ra_v[1], rrq_v[1], rrp_v[1], em_v[1], busy_v[1], done_v[1]}), 0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    cyc();

    // full-length run with early exit enabled
    run_op(0, 200, 255, 0, 0, lat, em_c, load_n, end_c);
    chk("full_lat", lat, 11);
    chk("full_em", em_c, 10);
    chk("full_loads", load_n, 1);
    chk("full_m", int'(m_a[0]), 51000);
    cyc();

    // Q = 0 exits after one ITER cycle
    run_op(0, 13, 0, 0, 0, lat, em_c, load_n, end_c);
    chk("q0_lat", lat, 4);
    chk("q0_em", em_c, 3);
    chk("q0_m", int'(m_a[0]), 0);

    // Q = 1
    run_op(0, 255, 1, 0, 0, lat, em_c, load_n, end_c);
    chk("q1_lat", lat, 5);
    chk("q1_m", int'(m_a[0]), 255);

    // no early exit: fixed latency
    run_op(1, 7, 2, 0, 0, lat, em_c, load_n, end_c);
    chk("noee_lat", lat, 11);
    chk("noee_m", int'(m_a[1]), 14);

    // start held high: back-to-back operations one IDLE cycle apart
    p_in[1] = 8'd3; q_in[1] = 8'd5; start_v[1] = 1'b1;
    d1 = -1; d2 = -1;
    for (int c = 1; c <= 40; c++) begin
      cyc();
      if (done_v[1]) begin
        if (d1 < 0) begin
          d1 = c;
          chk("held_m1", int'(m_a[1]), 15);
        end else if (d2 < 0) begin
          d2 = c;
          chk("held_m2", int'(m_a[1]), 15);
          start_v[1] = 1'b0;
        end
      end
    end
    start_v[1] = 1'b0;
    chk("held_first", d1, 11);
    chk("held_gap", d2 - d1, 12);
    for (int c = 0; c < 20 && busy_v[1]; c++) cyc();

    // start pulses during ITER are ignored
    run_op(0, 5, 6, 0, 32'h18, lat, em_c, load_n, end_c);
    chk("pulse_lat", lat, 7);
    chk("pulse_loads", load_n, 1);
    chk("pulse_m", int'(m_a[0]), 30);

    // abort mid-ITER keeps the previous product
    run_op(0, 200, 255, 0, 0, lat, em_c, load_n, end_c);
    chk("pre_abort_m", int'(m_a[0]), 51000);
    run_op(0, 9, 255, 5, 0, lat, em_c, load_n, end_c);
    chk("abort_done", lat, -1);
    chk("abort_idle", end_c, 6);
    chk("abort_m", int'(m_a[0]), 51000);
    run_op(0, 2, 3, 0, 0, lat, em_c, load_n, end_c);
    chk("post_abort_lat", lat, 6);
    chk("post_abort_m", int'(m_a[0]), 6);

    // asynchronous reset between clock edges mid-ITER
    p_in[0] = 8'd100; q_in[0] = 8'd200; start_v[0] = 1'b1;
    cyc();
    start_v[0] = 1'b0;
    repeat (3) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctl0", int'({ra_v[0], rrq_v[0], rrp_v[0], em_v[0], busy_v[0], done_v[0]}), 0);
    chk("async_rst_busy", int'(busy_v[0]), 0);
    cyc();
    rst_n = 1'b1;
    run_op(0, 10, 10, 0, 0, lat, em_c, load_n, end_c);
    chk("post_rst_lat", lat, 8);
    chk("post_rst_m", int'(m_a[0]), 100);

    // randomized traffic on both controllers
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!busy_v[i] && !start_v[i] && ($urandom_range(2) == 0)) begin
          p_in[i] = 8'($urandom);
          case ($urandom_range(3))
            0:       q_in[i] = 8'd0;
            1:       q_in[i] = 8'($urandom_range(15));
            default: q_in[i] = 8'($urandom);
          endcase
          start_v[i] = 1'b1;
        end else begin
          start_v[i] = ($urandom_range(7) == 0);
        end
        abort_v[i] = ($urandom_range(11) == 0);
      end
      cyc();
    end
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
    end
    repeat (20) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
